// File: rtl/vga_sincronismo.sv
// rtl/vga_sincronismo.sv - VGA 640x480@60 raster timing with pixel divider; frame counter under VGA_CONTADOR_QUADRO_EN
module vga_sincronismo #(
   parameter int H_VISIVEL = 640,
   parameter int H_FRENTE  = 16,
   parameter int H_SINC    = 96,
   parameter int H_TRAS    = 48,
   parameter int V_VISIVEL = 480,
   parameter int V_FRENTE  = 10,
   parameter int V_SINC    = 2,
   parameter int V_TRAS    = 33,
   parameter int CLK_DIV   = 2
) (
`ifdef VGA_CONTADOR_QUADRO_EN
   output logic [7:0] quadro,
`endif
   input  logic       clk,
   input  logic       rst_n,
   output logic       hsync,
   output logic       vsync,
   output logic       areaAtiva,
   output logic [9:0] linha,
   output logic [9:0] coluna,
   output logic       pixel_tick,
   output logic       fim_quadro
);

   localparam int H_TOTAL = H_VISIVEL + H_FRENTE + H_SINC + H_TRAS;
   localparam int V_TOTAL = V_VISIVEL + V_FRENTE + V_SINC + V_TRAS;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_ULT = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] COL_ULT = 10'(H_TOTAL - 1);
   localparam logic [9:0] LIN_ULT = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS   = 10'(H_VISIVEL);
   localparam logic [9:0] V_VIS   = 10'(V_VISIVEL);
   localparam logic [9:0] HS_INI  = 10'(H_VISIVEL + H_FRENTE);
   localparam logic [9:0] HS_FIM  = 10'(H_VISIVEL + H_FRENTE + H_SINC);
   localparam logic [9:0] VS_INI  = 10'(V_VISIVEL + V_FRENTE);
   localparam logic [9:0] VS_FIM  = 10'(V_VISIVEL + V_FRENTE + V_SINC);

   logic [DIV_W-1:0] r_div;
   logic [9:0]       r_coluna;
   logic [9:0]       r_linha;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_area;

   logic             w_tick;
   logic             w_fim_linha;
   logic             w_fim_quadro;
   logic [9:0]       w_col_prox;
   logic [9:0]       w_lin_prox;

   // Gated by rst_n so the strobe is quiet for the whole reset cycle, even with CLK_DIV=1.
   assign w_tick       = rst_n & (r_div == DIV_ULT);
   assign w_fim_linha  = w_tick & (r_coluna == COL_ULT);
   assign w_fim_quadro = w_fim_linha & (r_linha == LIN_ULT);

   always_comb begin
      w_col_prox = r_coluna;
      w_lin_prox = r_linha;
      if (w_tick) begin
         if (r_coluna == COL_ULT) begin
            w_col_prox = 10'd0;
            w_lin_prox = (r_linha == LIN_ULT) ? 10'd0 : r_linha + 10'd1;
         end else begin
            w_col_prox = r_coluna + 10'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_div <= '0;
      end else if (r_div == DIV_ULT) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // Sync/active flags decode the next position so they land on the same edge as the coordinates.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_coluna <= 10'd0;
         r_linha  <= 10'd0;
         r_hsync  <= 1'b1;
         r_vsync  <= 1'b1;
         r_area   <= 1'b1;
      end else begin
         r_coluna <= w_col_prox;
         r_linha  <= w_lin_prox;
         r_area   <= (w_col_prox < H_VIS) && (w_lin_prox < V_VIS);
         r_hsync  <= !((w_col_prox >= HS_INI) && (w_col_prox < HS_FIM));
         r_vsync  <= !((w_lin_prox >= VS_INI) && (w_lin_prox < VS_FIM));
      end
   end

`ifdef VGA_CONTADOR_QUADRO_EN
   logic [7:0] r_quadro;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_quadro <= 8'd0;
      end else if (w_fim_quadro) begin
         r_quadro <= r_quadro + 8'd1;
      end
   end

   assign quadro = r_quadro;
`endif

   assign hsync      = r_hsync;
   assign vsync      = r_vsync;
   assign areaAtiva  = r_area;
   assign linha      = r_linha;
   assign coluna     = r_coluna;
   assign pixel_tick = w_tick;
   assign fim_quadro = w_fim_quadro;

endmodule
